// File: rtl/ifid_skid_reg.sv
// IF/ID pipeline boundary register with a one-entry skid buffer.
// Fetch hands {pc, instr} pairs in through a valid/ready handshake, and
// decode takes them out through its own valid/ready handshake. The skid
// entry absorbs the one extra pair that fetch issues after decode stalls.
// A flush squashes every held pair and leaves an all-zero NOP bubble.
// A saturating counter records the decode back-pressure cycles.
module ifid_skid_reg #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               arst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [CNT_W-1:0]   stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_HALF  = 2'b01,
    ST_FULL  = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t             state_q, state_d;
  logic [PC_W-1:0]    main_pc_q, main_pc_d;
  logic [INSTR_W-1:0] main_instr_q, main_instr_d;
  logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic acc;
  logic take;

  // Both handshakes use registered flags only, so in_ready never sees out_ready.
  always_comb begin
    acc  = in_valid & in_ready_q;
    take = out_valid_q & out_ready;
  end

  // Next state and datapath: flush wins over every handshake transition.
  always_comb begin
    state_d      = state_q;
    main_pc_d    = main_pc_q;
    main_instr_d = main_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;

    if (flush) begin
      state_d      = ST_EMPTY;
      main_pc_d    = '0;
      main_instr_d = '0;
      skid_pc_d    = '0;
      skid_instr_d = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            main_pc_d    = in_pc;
            main_instr_d = in_instr;
            state_d      = ST_HALF;
          end
        end
        ST_HALF: begin
          if (acc && take) begin
            // Pass-through: the new pair replaces the one decode consumed.
            main_pc_d    = in_pc;
            main_instr_d = in_instr;
          end else if (acc) begin
            skid_pc_d    = in_pc;
            skid_instr_d = in_instr;
            state_d      = ST_FULL;
          end else if (take) begin
            // Clearing main keeps out_* at zero while nothing is valid.
            main_pc_d    = '0;
            main_instr_d = '0;
            state_d      = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (take) begin
            main_pc_d    = skid_pc_q;
            main_instr_d = skid_instr_q;
            skid_pc_d    = '0;
            skid_instr_d = '0;
            state_d      = ST_HALF;
          end
        end
        default: begin
          // Unreachable encoding: recover to a clean empty register.
          state_d      = ST_EMPTY;
          main_pc_d    = '0;
          main_instr_d = '0;
          skid_pc_d    = '0;
          skid_instr_d = '0;
        end
      endcase
    end
  end

  // Handshake flags are decoded from the next state so they come straight off flops.
  always_comb begin
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_FULL);
  end

  // Saturating count of cycles where decode holds off a valid pair.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_q && !out_ready && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  // State, data and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (arst) begin
      state_q      <= ST_EMPTY;
      main_pc_q    <= '0;
      main_instr_q <= '0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b1;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      main_pc_q    <= main_pc_d;
      main_instr_q <= main_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      out_valid_q  <= out_valid_d;
      in_ready_q   <= in_ready_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  // Main register always feeds decode; it is zero whenever out_valid is low.
  always_comb begin
    in_ready  = in_ready_q;
    out_valid = out_valid_q;
    out_pc    = main_pc_q;
    out_instr = main_instr_q;
    stall_cnt = stall_cnt_q;
  end

endmodule

// File: tb/tb_ifid_skid_reg.sv
// Self-checking bench for ifid_skid_reg: directed scenarios plus a random
// soak against a queue-based reference model.
module tb_ifid_skid_reg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk;
  logic               arst;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [PC_W-1:0]    in_pc;
  logic [INSTR_W-1:0] in_instr;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instr;
  logic [CNT_W-1:0]   stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: ordered list of held pairs plus a stall count.
  logic [PC_W+INSTR_W-1:0] mq[$];
  int                      m_cnt = 0;

  ifid_skid_reg #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .arst(arst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle: update the model from the inputs seen at the edge,
  // then return at the falling edge where outputs are sampled.
  task automatic tick();
    bit vld, rdy;
    vld = (mq.size() > 0);
    rdy = (mq.size() < 2);
    if (arst) begin
      mq.delete();
      m_cnt = 0;
    end else begin
      if (vld && !out_ready && m_cnt < CNT_MAX) m_cnt++;
      if (flush) begin
        mq.delete();
      end else begin
        if (vld && out_ready) void'(mq.pop_front());
        if (in_valid && rdy) mq.push_back({in_pc, in_instr});
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    flush = 0; in_valid = 0; out_ready = 0; in_pc = '0; in_instr = '0;
  endtask

  task automatic test_reset();
    arst = 1; flush = 1; in_valid = 1; out_ready = 0;
    in_pc = 32'hDEAD_0000; in_instr = 32'h1234_5678;
    tick(); tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_pc !== '0) begin n_err++; $display("FAIL reset_out_pc got %h want 0", out_pc); end
    n_cmp++; if (out_instr !== '0) begin n_err++; $display("FAIL reset_out_instr got %h want 0", out_instr); end
    n_cmp++; if (stall_cnt !== '0) begin n_err++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
    $display("test_reset: out_valid=%b in_ready=%b stall_cnt=%0d", out_valid, in_ready, stall_cnt);
    arst = 0; idle_inputs();
    tick();
  endtask

  task automatic test_streaming();
    logic [PC_W-1:0] pcs [3];
    pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108;
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_pc = pcs[i]; in_instr = 32'h2000_0000 | i;
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== pcs[i]) begin
        n_err++; $display("FAIL stream_%0d got v=%b pc=%h want v=1 pc=%h", i, out_valid, out_pc, pcs[i]);
      end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready_%0d got %b want 1", i, in_ready); end
      $display("test_streaming: pc=%h instr=%h in_ready=%b", out_pc, out_instr, in_ready);
    end
    in_valid = 0;
    tick();
    n_cmp++; if (out_valid !== 1'b0 || out_pc !== '0) begin
      n_err++; $display("FAIL stream_drain got v=%b pc=%h want v=0 pc=0", out_valid, out_pc);
    end
    idle_inputs();
  endtask

  task automatic test_skid();
    out_ready = 0; in_valid = 1; in_pc = 32'h200; in_instr = 32'hAAAA_0200;
    tick();
    in_pc = 32'h204; in_instr = 32'hAAAA_0204;
    tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL skid_full_ready got %b want 0", in_ready); end
    n_cmp++; if (out_pc !== 32'h200 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL skid_hold got v=%b pc=%h want v=1 pc=200", out_valid, out_pc);
    end
    $display("test_skid: held pc=%h in_ready=%b", out_pc, in_ready);
    in_valid = 0; out_ready = 1;
    tick();
    n_cmp++; if (out_pc !== 32'h204 || out_instr !== 32'hAAAA_0204) begin
      n_err++; $display("FAIL skid_drain got pc=%h instr=%h want pc=204 instr=aaaa0204", out_pc, out_instr);
    end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL skid_ready_back got %b want 1", in_ready); end
    $display("test_skid: drained pc=%h in_ready=%b", out_pc, in_ready);
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL skid_empty got %b want 0", out_valid); end
    idle_inputs();
  endtask

  task automatic test_flush_full();
    out_ready = 0; in_valid = 1; in_pc = 32'h300; in_instr = 32'hBBBB_0300;
    tick();
    in_pc = 32'h304; in_instr = 32'hBBBB_0304;
    tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_pre_full got %b want 0", in_ready); end
    in_pc = 32'h308; in_instr = 32'hBBBB_0308; flush = 1;
    tick();
    n_cmp++; if (out_valid !== 1'b0 || out_instr !== '0 || out_pc !== '0) begin
      n_err++; $display("FAIL flush_bubble got v=%b pc=%h instr=%h want all 0", out_valid, out_pc, out_instr);
    end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready got %b want 1", in_ready); end
    $display("test_flush_full: out_valid=%b in_ready=%b", out_valid, in_ready);
    flush = 0; in_valid = 0; out_ready = 1;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_dropped got v=%b pc=%h want v=0", out_valid, out_pc);
    end
    idle_inputs();
  endtask

  task automatic test_counter();
    arst = 1; tick(); arst = 0;
    in_valid = 1; out_ready = 0; in_pc = 32'h400; in_instr = 32'hCCCC_0400;
    tick();
    in_valid = 0;
    for (int i = 0; i < 20; i++) tick();
    n_cmp++; if (stall_cnt !== 4'd15) begin n_err++; $display("FAIL cnt_saturate got %0d want 15", stall_cnt); end
    $display("test_counter: after 20 stalls stall_cnt=%0d", stall_cnt);
    flush = 1; tick(); flush = 0;
    n_cmp++; if (stall_cnt !== 4'd15) begin n_err++; $display("FAIL cnt_after_flush got %0d want 15", stall_cnt); end
    arst = 1; tick(); arst = 0;
    n_cmp++; if (stall_cnt !== 4'd0) begin n_err++; $display("FAIL cnt_after_reset got %0d want 0", stall_cnt); end
    $display("test_counter: after flush/reset stall_cnt=%0d", stall_cnt);
    idle_inputs();
  endtask

  task automatic test_soak();
    int errs_before;
    logic [PC_W+INSTR_W-1:0] head;
    errs_before = n_err;
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      arst      = ($urandom_range(0, 999) == 0);
      in_pc     = $urandom;
      in_instr  = $urandom;
      tick();
      head = (mq.size() > 0) ? mq[0] : '0;
      n_cmp++; if (out_valid !== (mq.size() > 0)) begin
        n_err++; $display("FAIL soak_valid cyc %0d got %b want %b", c, out_valid, mq.size() > 0);
      end
      n_cmp++; if (in_ready !== (mq.size() < 2)) begin
        n_err++; $display("FAIL soak_ready cyc %0d got %b want %b", c, in_ready, mq.size() < 2);
      end
      n_cmp++; if ({out_pc, out_instr} !== head) begin
        n_err++; $display("FAIL soak_data cyc %0d got %h_%h want %h", c, out_pc, out_instr, head);
      end
      n_cmp++; if (stall_cnt !== m_cnt[CNT_W-1:0]) begin
        n_err++; $display("FAIL soak_cnt cyc %0d got %0d want %0d", c, stall_cnt, m_cnt);
      end
    end
    arst = 0; idle_inputs();
    $display("test_soak: 10000 cycles, %0d mismatches", n_err - errs_before);
  endtask

  initial begin
    arst = 1; idle_inputs();
    test_reset();
    test_streaming();
    test_skid();
    test_flush_full();
    test_counter();
    test_soak();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ifid_skid_reg.md
# ifid_skid_reg

IF/ID pipeline boundary register for the pipelined MIPS core. It captures a fetched {PC, instruction} pair from the fetch stage and presents it to decode through a valid/ready handshake. A one-entry skid buffer lets fetch keep issuing for one cycle after decode stalls. It replaces a bare enable-gated flop bank at this boundary, adding bubble insertion on flush and a saturating stall counter for performance monitoring.

## Interface

Parameters:
- PC_W, 32, width of the PC field.
- INSTR_W, 32, width of the instruction field.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  input  1  rising-edge clock.
- arst  input  1  reset, synchronous, active-high.
- flush  input  1  synchronous squash of all held entries (branch/jump redirect).
- in_valid  input  1  fetch presents a valid pair.
- in_ready  output  1  block can accept a pair this cycle; registered.
- in_pc  input  PC_W  fetched PC.
- in_instr  input  INSTR_W  fetched instruction.
- out_valid  output  1  decode-side pair valid.
- out_ready  input  1  decode consumes the pair this cycle.
- out_pc  output  PC_W  PC presented to decode.
- out_instr  output  INSTR_W  instruction presented to decode.
- stall_cnt  output  CNT_W  saturating count of decode back-pressure cycles.

## Operation

- Storage: a main register {main_pc, main_instr}, which drives out_pc and out_instr; a skid register {skid_pc, skid_instr}; and a 2-bit state.
- States:
  - EMPTY: out_valid=0, in_ready=1.
  - HALF: main register full, out_valid=1, in_ready=1.
  - FULL: main and skid both full, out_valid=1, in_ready=0.
- Definitions: acc = in_valid & in_ready; take = out_valid & out_ready.
- Transitions when flush=0:
  - EMPTY & acc: main <= in; go to HALF.
  - HALF & acc & take: main <= in; stay in HALF.
  - HALF & acc & !take: skid <= in; go to FULL.
  - HALF & !acc & take: go to EMPTY. main_* is cleared to 0.
  - FULL & take: main <= skid; go to HALF. No acceptance is possible in FULL.
  - All other cases hold state and data.
- Flush: has priority over every transition above.
  - The next state is EMPTY.
  - main_* and skid_* are cleared to 0. An all-zero instruction is the MIPS NOP bubble.
  - A pair offered in the flush cycle is dropped, even if in_ready=1.
- Data outputs: out_pc and out_instr are 0 whenever out_valid=0.
- Ordering: pairs leave in the order they were accepted. No pair is lost or duplicated except by flush.
- in_ready is a flop output: in_ready = (next_state != FULL), registered. It must never combinationally depend on out_ready.
- stall_cnt:
  - Increments by 1 on each cycle with out_valid=1 and out_ready=0.
  - Saturates at 2^CNT_W-1.
  - Is not affected by flush; it is cleared only by arst.
- Reset (arst=1 at a rising edge): state=EMPTY, out_valid=0, in_ready=1, out_pc=0, out_instr=0, all skid bits 0, stall_cnt=0. Reset overrides flush and any handshake in the same cycle.

## Timing

- Latency is 1 cycle: a pair accepted at edge N is visible on out_* after edge N, with out_valid=1 in cycle N+1.
- Sustained throughput is one pair per cycle while out_ready=1.
- When out_ready drops, one additional pair can still be accepted. in_ready goes to 0 in the cycle after the skid buffer fills.
- After out_ready returns, the skid buffer drains to main at the next edge, and in_ready=1 in the following cycle.
- Flush takes effect at the edge where it is sampled. out_valid=0 and in_ready=1 in the next cycle.
- Reset asserted mid-stream, in any state, drops all held pairs and yields reset values after the edge.
- Simultaneous acc and take in HALF is a pass-through with no state change. It must not enter FULL.

## Test plan

- Reset: hold arst for 2 cycles with in_valid=1 and flush=1 -> out_valid=0, in_ready=1, out_pc=0, out_instr=0, stall_cnt=0.
- Streaming: offer PC 0x100, 0x104, 0x108 on consecutive cycles with out_ready=1 -> out_pc shows 0x100, 0x104, 0x108 in cycles 1, 2 and 3; state never reaches FULL.
- Skid: keep out_valid=1 with PC 0x200 held, drop out_ready, and offer PC 0x204 -> in_ready=0 on the next cycle. Raise out_ready -> 0x200, then 0x204 appear in order, and in_ready returns to 1.
- Flush in FULL, with 0x300 and 0x304 held and PC 0x308 offered in the same cycle -> out_valid=0 and out_instr=0 the next cycle. 0x308 is never presented, and in_ready=1.
- Counter saturation with CNT_W=4: hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt reads 15. A flush then leaves stall_cnt at 15; arst sets it to 0.
- Random soak: random in_valid, out_ready and flush for 10k cycles, checked against a reference queue model -> no loss, no duplication, order preserved, and in_ready=0 only in FULL.
